// File: rtl/csr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : csr_pkg
//  Description : Shared encodings for the Zicsr read-modify-write sequencer:
//                operation codes, sequencer states, privilege levels, CSR
//                addresses, and the write-required predicate.
//  Revision    : 1.0  initial release
// ============================================================================
package csr_pkg;

    localparam int XLEN_DEFAULT = 64;

    typedef enum logic [1:0] {
        CSR_OP_RSVD = 2'b00,
        CSR_OP_RW   = 2'b01,
        CSR_OP_RS   = 2'b10,
        CSR_OP_RC   = 2'b11
    } csr_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } csr_state_e;

    localparam logic [1:0] PRV_U = 2'b00;
    localparam logic [1:0] PRV_S = 2'b01;
    localparam logic [1:0] PRV_M = 2'b11;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MVENDORID = 12'hF11;
    localparam logic [11:0] CSR_MARCHID   = 12'hF12;
    localparam logic [11:0] CSR_MIMPID    = 12'hF13;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    // RW always writes; RS/RC write only when the source operand is nonzero.
    function automatic logic csr_write_req(input logic [1:0] op, input logic suppress);
        return (op == CSR_OP_RW) ||
               (((op == CSR_OP_RS) || (op == CSR_OP_RC)) && !suppress);
    endfunction

endpackage
`default_nettype wire

// File: rtl/csr_perm_check.sv
`default_nettype none
// ============================================================================
//  Module      : csr_perm_check
//  Description : Combinational legality check for a CSR access: reserved op,
//                unimplemented CSR, insufficient privilege, or a write to a
//                read-only CSR. Shared with the debug CSR path.
//  Revision    : 1.0  initial release
// ============================================================================
module csr_perm_check
    import csr_pkg::*;
(
    input  logic [11:0] addr_i,
    input  logic [1:0]  priv_i,
    input  logic [1:0]  op_i,
    input  logic        suppress_i,
    input  logic        hit_i,
    output logic        illegal_o
);

    // Only the privilege and read-only fields of the address matter here.
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr_i[7:0];

    // Any single violation makes the access illegal.
    always_comb begin
        illegal_o = 1'b0;
        if (op_i == CSR_OP_RSVD)                                   illegal_o = 1'b1;
        if (!hit_i)                                                illegal_o = 1'b1;
        if (addr_i[9:8] > priv_i)                                  illegal_o = 1'b1;
        if ((addr_i[11:10] == 2'b11) && csr_write_req(op_i, suppress_i)) illegal_o = 1'b1;
    end

endmodule
`default_nettype wire

// File: rtl/csr_rmw_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : csr_rmw_ctrl
//  Description : One-at-a-time Zicsr sequencer. Reads the target CSR, checks
//                legality, writes back the RW/RS/RC result in a single-cycle
//                strobe, and returns the old value with an illegal flag.
//                Sole writer of the CSR bank write port.
//  Revision    : 1.0  initial release
// ============================================================================
module csr_rmw_ctrl
    import csr_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [11:0]     req_addr,
    input  logic [1:0]      req_op,
    input  logic [XLEN-1:0] req_wdata,
    input  logic            req_wr_suppress,
    input  logic [1:0]      req_priv,
    output logic [11:0]     csr_raddr,
    input  logic [XLEN-1:0] csr_rdata,
    input  logic            csr_hit,
    output logic            csr_we,
    output logic [11:0]     csr_waddr,
    output logic [XLEN-1:0] csr_wdata,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_illegal,
    output logic            busy
);

    csr_state_e      state_q, state_d;
    logic [11:0]     addr_q,  addr_d;
    csr_op_e         op_q,    op_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic            sup_q,   sup_d;
    logic [1:0]      priv_q,  priv_d;
    logic [XLEN-1:0] old_q,   old_d;
    logic [XLEN-1:0] new_q,   new_d;
    logic            ill_q,   ill_d;

    logic            illegal_w;
    logic            wr_req_w;
    logic [XLEN-1:0] mod_val_w;

    // Legality is judged against the live bank hit during READ.
    csr_perm_check u_perm_check (
        .addr_i     (addr_q),
        .priv_i     (priv_q),
        .op_i       (op_q),
        .suppress_i (sup_q),
        .hit_i      (csr_hit),
        .illegal_o  (illegal_w)
    );

    assign wr_req_w = csr_write_req(op_q, sup_q);

    // Full-width RW/RS/RC update; WARL masking is left to the bank.
    always_comb begin
        mod_val_w = '0;
        case (op_q)
            CSR_OP_RW: mod_val_w = wdata_q;
            CSR_OP_RS: mod_val_w = csr_rdata | wdata_q;
            CSR_OP_RC: mod_val_w = csr_rdata & ~wdata_q;
            default:   mod_val_w = '0;
        endcase
    end

    // State and datapath registers, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            op_q    <= CSR_OP_RSVD;
            wdata_q <= '0;
            sup_q   <= 1'b0;
            priv_q  <= PRV_U;
            old_q   <= '0;
            new_q   <= '0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            op_q    <= op_d;
            wdata_q <= wdata_d;
            sup_q   <= sup_d;
            priv_q  <= priv_d;
            old_q   <= old_d;
            new_q   <= new_d;
            ill_q   <= ill_d;
        end
    end

    // Next-state sequencing IDLE -> READ -> [WRITE] -> RESP -> IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (req_valid) state_d = ST_READ;
            ST_READ: begin
                if (illegal_w)     state_d = ST_RESP;
                else if (wr_req_w) state_d = ST_WRITE;
                else               state_d = ST_RESP;
            end
            ST_WRITE: state_d = ST_RESP;
            ST_RESP:  if (resp_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Latch the request on accept; capture old value, result and flag in READ.
    always_comb begin
        addr_d  = addr_q;
        op_d    = op_q;
        wdata_d = wdata_q;
        sup_d   = sup_q;
        priv_d  = priv_q;
        old_d   = old_q;
        new_d   = new_q;
        ill_d   = ill_q;
        if ((state_q == ST_IDLE) && req_valid) begin
            addr_d  = req_addr;
            op_d    = csr_op_e'(req_op);
            wdata_d = req_wdata;
            sup_d   = req_wr_suppress;
            priv_d  = req_priv;
        end
        if (state_q == ST_READ) begin
            ill_d = illegal_w;
            old_d = illegal_w ? '0 : csr_rdata;
            new_d = mod_val_w;
        end
    end

    // Outputs decoded from state; idle values are zero so reset looks clean.
    always_comb begin
        req_ready    = (state_q == ST_IDLE);
        busy         = (state_q != ST_IDLE);
        csr_raddr    = (state_q == ST_READ)  ? addr_q : 12'h000;
        csr_we       = (state_q == ST_WRITE);
        csr_waddr    = (state_q == ST_WRITE) ? addr_q : 12'h000;
        csr_wdata    = (state_q == ST_WRITE) ? new_q  : '0;
        resp_valid   = (state_q == ST_RESP);
        resp_rdata   = (state_q == ST_RESP)  ? old_q  : '0;
        resp_illegal = (state_q == ST_RESP)  ? ill_q  : 1'b0;
    end

endmodule
`default_nettype wire

// File: tb/tb_csr_rmw_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_csr_rmw_ctrl
//  Description : Self-checking bench for csr_rmw_ctrl with a behavioural CSR
//                bank, a vector table and an expected-response queue.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_csr_rmw_ctrl;
    import csr_pkg::*;

    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic [11:0]     req_addr = '0;
    logic [1:0]      req_op = '0;
    logic [XLEN-1:0] req_wdata = '0;
    logic            req_wr_suppress = 1'b0;
    logic [1:0]      req_priv = '0;
    logic [11:0]     csr_raddr;
    logic [XLEN-1:0] csr_rdata;
    logic            csr_hit;
    logic            csr_we;
    logic [11:0]     csr_waddr;
    logic [XLEN-1:0] csr_wdata;
    logic            resp_valid;
    logic            resp_ready = 1'b0;
    logic [XLEN-1:0] resp_rdata;
    logic            resp_illegal;
    logic            busy;

    int n_checks = 0;
    int n_fail   = 0;
    int we_total = 0;

    always #5 clk = ~clk;

    csr_rmw_ctrl #(.XLEN(XLEN)) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_addr        (req_addr),
        .req_op          (req_op),
        .req_wdata       (req_wdata),
        .req_wr_suppress (req_wr_suppress),
        .req_priv        (req_priv),
        .csr_raddr       (csr_raddr),
        .csr_rdata       (csr_rdata),
        .csr_hit         (csr_hit),
        .csr_we          (csr_we),
        .csr_waddr       (csr_waddr),
        .csr_wdata       (csr_wdata),
        .resp_valid      (resp_valid),
        .resp_ready      (resp_ready),
        .resp_rdata      (resp_rdata),
        .resp_illegal    (resp_illegal),
        .busy            (busy)
    );

    // Behavioural CSR bank: combinational read, write on csr_we.
    logic [XLEN-1:0] bank [4096];
    bit bank_loaded = 1'b0;

    function automatic bit is_impl(input logic [11:0] a);
        return (a == CSR_MSTATUS) || (a == CSR_MISA) || (a == CSR_MVENDORID) ||
               (a == CSR_MARCHID) || (a == CSR_MIMPID) || (a == CSR_MHARTID) ||
               (a == 12'h100);
    endfunction

    assign csr_rdata = bank[csr_raddr];
    assign csr_hit   = is_impl(csr_raddr);

    always @(posedge clk) begin
        if (!bank_loaded) begin
            for (int i = 0; i < 4096; i++) bank[i] <= '0;
            bank[CSR_MISA]      <= 64'h0A0101;
            bank[CSR_MSTATUS]   <= 64'h8;
            bank[CSR_MVENDORID] <= 64'h489;
            bank[CSR_MARCHID]   <= 64'h5;
            bank[CSR_MIMPID]    <= 64'h7;
            bank[CSR_MHARTID]   <= 64'h3;
            bank[12'h100]       <= 64'h22;
            bank_loaded <= 1'b1;
        end else if (csr_we) begin
            bank[csr_waddr] <= csr_wdata;
        end
        if (csr_we) we_total <= we_total + 1;
    end

    typedef struct {
        logic [11:0]     addr;
        logic [1:0]      op;
        logic [XLEN-1:0] wdata;
        logic            sup;
        logic [1:0]      priv;
        int              stall;
        logic [XLEN-1:0] e_rdata;
        logic            e_ill;
        logic            e_we;
        logic [XLEN-1:0] e_wdata;
        int              e_lat;
    } vec_t;

    typedef struct {
        logic [XLEN-1:0] rdata;
        logic            ill;
        logic            we;
        logic [XLEN-1:0] wdata;
        logic [11:0]     waddr;
        int              lat;
    } exp_t;

    exp_t sb[$];
    vec_t vecs [13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".req_ready"},    64'(req_ready),    64'd1);
        check({tag, ".busy"},         64'(busy),         64'd0);
        check({tag, ".csr_we"},       64'(csr_we),       64'd0);
        check({tag, ".resp_valid"},   64'(resp_valid),   64'd0);
        check({tag, ".resp_illegal"}, 64'(resp_illegal), 64'd0);
        check({tag, ".csr_raddr"},    64'(csr_raddr),    64'd0);
        check({tag, ".csr_waddr"},    64'(csr_waddr),    64'd0);
        check({tag, ".csr_wdata"},    csr_wdata,         64'd0);
        check({tag, ".resp_rdata"},   resp_rdata,        64'd0);
    endtask

    task automatic wait_ready(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready) begin ok = 1'b1; break; end
        end
        check({tag, ".ready_timeout"}, 64'(ok), 64'd1);
    endtask

    task automatic drive_req(input vec_t v);
        req_addr        = v.addr;
        req_op          = v.op;
        req_wdata       = v.wdata;
        req_wr_suppress = v.sup;
        req_priv        = v.priv;
        req_valid       = 1'b1;
        @(posedge clk);
        #1;
        req_valid       = 1'b0;
        req_op          = 2'b00;
        req_wdata       = '0;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int          we_cnt   = 0;
        int          we_cyc   = 0;
        int          resp_cyc = 0;
        logic [63:0] we_data  = '0;
        logic [11:0] we_addr  = '0;
        bit          rdy_err  = 1'b0;
        exp_t        e;
        wait_ready(tag);
        sb.push_back('{v.e_rdata, v.e_ill, v.e_we, v.e_wdata, v.addr, v.e_lat});
        drive_req(v);
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (csr_we) begin
                we_cnt++;
                we_cyc  = c;
                we_data = csr_wdata;
                we_addr = csr_waddr;
            end
            if (req_ready) rdy_err = 1'b1;
            if (resp_valid) begin resp_cyc = c; break; end
        end
        e = sb.pop_front();
        check({tag, ".resp_latency"}, 64'(resp_cyc), 64'(e.lat));
        check({tag, ".resp_rdata"},   resp_rdata,    e.rdata);
        check({tag, ".resp_illegal"}, 64'(resp_illegal), 64'(e.ill));
        check({tag, ".we_count"},     64'(we_cnt),   64'(e.we));
        check({tag, ".req_ready_low"}, 64'(rdy_err), 64'd0);
        if (e.we) begin
            check({tag, ".we_cycle"}, 64'(we_cyc),  64'd2);
            check({tag, ".we_data"},  we_data,      e.wdata);
            check({tag, ".we_addr"},  64'(we_addr), 64'(e.waddr));
        end
        for (int s = 0; s < v.stall; s++) begin
            @(negedge clk);
            check($sformatf("%s.stall%0d.resp_valid", tag, s), 64'(resp_valid), 64'd1);
            check($sformatf("%s.stall%0d.resp_rdata", tag, s), resp_rdata, e.rdata);
            check($sformatf("%s.stall%0d.req_ready", tag, s),  64'(req_ready), 64'd0);
            check($sformatf("%s.stall%0d.csr_we", tag, s),     64'(csr_we), 64'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        @(negedge clk);
        check({tag, ".idle_ready"}, 64'(req_ready), 64'd1);
        check({tag, ".idle_busy"},  64'(busy),      64'd0);
    endtask

    initial begin
        int we_snap;
        // addr, op, wdata, sup, priv, stall, e_rdata, e_ill, e_we, e_wdata, e_lat
        vecs[0]  = '{CSR_MISA,      CSR_OP_RS, 64'h0,    1'b1, PRV_M, 0, 64'h0A0101, 1'b0, 1'b0, 64'h0,  2};
        vecs[1]  = '{CSR_MVENDORID, CSR_OP_RW, 64'h1234, 1'b0, PRV_M, 0, 64'h0,      1'b1, 1'b0, 64'h0,  2};
        vecs[2]  = '{CSR_MSTATUS,   CSR_OP_RS, 64'h2,    1'b0, PRV_M, 0, 64'h8,      1'b0, 1'b1, 64'hA,  3};
        vecs[3]  = '{CSR_MSTATUS,   CSR_OP_RC, 64'h8,    1'b0, PRV_M, 0, 64'hA,      1'b0, 1'b1, 64'h2,  3};
        vecs[4]  = '{CSR_MSTATUS,   CSR_OP_RS, 64'h1,    1'b0, PRV_U, 0, 64'h0,      1'b1, 1'b0, 64'h0,  2};
        vecs[5]  = '{CSR_MSTATUS,   2'b00,     64'h1,    1'b0, PRV_M, 0, 64'h0,      1'b1, 1'b0, 64'h0,  2};
        vecs[6]  = '{12'h7FF,       CSR_OP_RS, 64'h1,    1'b0, PRV_M, 0, 64'h0,      1'b1, 1'b0, 64'h0,  2};
        vecs[7]  = '{CSR_MSTATUS,   CSR_OP_RW, 64'h55,   1'b0, PRV_M, 5, 64'h2,      1'b0, 1'b1, 64'h55, 3};
        vecs[8]  = '{CSR_MHARTID,   CSR_OP_RS, 64'h0,    1'b1, PRV_M, 0, 64'h3,      1'b0, 1'b0, 64'h0,  2};
        vecs[9]  = '{12'h100,       CSR_OP_RW, 64'h33,   1'b0, PRV_S, 0, 64'h22,     1'b0, 1'b1, 64'h33, 3};
        vecs[10] = '{CSR_MSTATUS,   CSR_OP_RS, 64'h0,    1'b1, PRV_S, 0, 64'h0,      1'b1, 1'b0, 64'h0,  2};
        vecs[11] = '{CSR_MIMPID,    CSR_OP_RS, 64'h1,    1'b0, PRV_M, 0, 64'h0,      1'b1, 1'b0, 64'h0,  2};
        vecs[12] = '{CSR_MISA,      CSR_OP_RC, 64'h0,    1'b1, PRV_M, 0, 64'h0A0101, 1'b0, 1'b0, 64'h0,  2};

        // Power-on reset
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("por");
        rst = 1'b1;

        for (int i = 0; i < 13; i++) run_vec(vecs[i], $sformatf("v%0d", i));

        // Reset while a write-bound request sits in READ
        wait_ready("rst_mid");
        we_snap = we_total;
        drive_req('{CSR_MSTATUS, CSR_OP_RW, 64'h77, 1'b0, PRV_M, 0, 64'h0, 1'b0, 1'b1, 64'h77, 3});
        @(negedge clk);
        check("rst_mid.in_read_busy", 64'(busy), 64'd1);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst_mid");
        rst = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_mid.no_we_after", 64'(we_total - we_snap), 64'd0);
        check("rst_mid.bank_intact", bank[CSR_MSTATUS], 64'h55);

        run_vec('{CSR_MSTATUS, CSR_OP_RS, 64'h0, 1'b1, PRV_M, 0, 64'h55, 1'b0, 1'b0, 64'h0, 2}, "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/csr_rmw_ctrl.md
# csr_rmw_ctrl

Sequencer for Zicsr instructions (CSRRW/CSRRS/CSRRC and immediate forms). It accepts one CSR request at a time from the execute stage and reads the target CSR from the CSR bank, including the machine read-only ID registers. It checks privilege and read-only rules, computes and writes back the modified value, then returns the old value and an illegal flag to the pipeline. It sits between the execute unit and the CSR bank and is the only writer of the bank's write port.

## Interface
Parameters:
- XLEN, 64, CSR data width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept.
- req_addr  in  12  CSR address.
- req_op  in  2  01=RW, 10=RS, 11=RC, 00 reserved.
- req_wdata  in  XLEN  rs1 value or zero-extended uimm.
- req_wr_suppress  in  1  RS/RC with rs1/uimm=0: no write.
- req_priv  in  2  current privilege (00 U, 01 S, 11 M).
- csr_raddr  out  12  bank read address.
- csr_rdata  in  XLEN  bank read data, combinational from csr_raddr.
- csr_hit  in  1  csr_raddr is implemented.
- csr_we  out  1  bank write strobe, one-cycle pulse.
- csr_waddr  out  12  bank write address.
- csr_wdata  out  XLEN  bank write data.
- resp_valid  out  1  response present.
- resp_ready  in  1  pipeline takes response.
- resp_rdata  out  XLEN  old CSR value; 0 when illegal.
- resp_illegal  out  1  raise illegal-instruction.
- busy  out  1  state != IDLE.

## Operation
- States: IDLE, READ, WRITE, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch addr, op, wdata, suppress, priv, then go to READ.
- READ:
  - csr_raddr=latched addr.
  - Capture csr_rdata and csr_hit.
  - Evaluate illegal, which is true if any of the following hold:
    - op==00.
    - !csr_hit.
    - addr[9:8] > priv.
    - addr[11:10]==2'b11 and write not suppressed.
  - If illegal, go to RESP.
  - Otherwise go to WRITE if a write is required, else RESP.
- Write required: op==RW, or (op∈{RS,RC} and !suppress).
- New value:
  - RW: wdata.
  - RS: old | wdata.
  - RC: old & ~wdata.
  - Full XLEN bitwise; no masking. The bank applies WARL.
- WRITE:
  - csr_we=1 for exactly this cycle, with csr_waddr and csr_wdata valid.
  - Always go to RESP.
- RESP:
  - resp_valid=1; resp_rdata and resp_illegal stable.
  - On resp_ready, go to IDLE.

## Timing
- Reset values:
  - State IDLE.
  - req_ready=1.
  - busy, csr_we, resp_valid, resp_illegal = 0.
  - csr_raddr, csr_waddr, csr_wdata, resp_rdata = 0.
- Latency, with accept at cycle 0:
  - READ at cycle 1.
  - WRITE at cycle 2 (csr_we high).
  - resp_valid first high at cycle 3.
  - Without a write, resp_valid is first high at cycle 2.
- No pipelining:
  - req_ready is low from the cycle after accept until the cycle after the response handshake.
  - A new request can be accepted no earlier than one cycle after resp_valid&&resp_ready.
- resp_valid holds with stable data while resp_ready=0, for unbounded stalls.
- Reset mid-operation:
  - Next cycle IDLE with reset outputs.
  - A pending WRITE is abandoned; csr_we is never asserted after rst low.
- csr_we asserts at most once per request and never for illegal requests.

## Structure
- Shared package csr_pkg:
  - op encodings (CSR_OP_RW/RS/RC).
  - state enum.
  - privilege constants PRV_U/S/M.
  - CSR address constants (MISA 0x301, MVENDORID 0xF11, MARCHID 0xF12, MIMPID 0xF13, MHARTID 0xF14, MSTATUS 0x300).
- One sub-module, csr_perm_check: combinational (addr, priv, op, suppress, hit) -> illegal. It is reused by the debug CSR path.

## Test plan
- RS 0x301, suppress=1, priv=M, bank misa=0x0A0101 -> resp_rdata=0x0A0101, illegal=0, csr_we never asserted, resp_valid at cycle 2.
- RW 0xF11, wdata=0x1234, priv=M -> illegal=1, resp_rdata=0, no csr_we.
- RS 0x300, old=0x8, wdata=0x2, priv=M -> csr_we at cycle 2 with wdata=0xA, resp_rdata=0x8 at cycle 3; then RC same CSR old=0xA, wdata=0x8 -> write 0x2.
- RS 0x300 with priv=U; separately op=00 on 0x300; separately unimplemented 0x7FF (csr_hit=0) -> each illegal=1, no write.
- RW 0x300, resp_ready low 5 cycles -> resp_valid and data held stable, req_ready=0 throughout; handshake -> IDLE, next request accepted one cycle later.
- rst low during WRITE-bound READ -> no csr_we afterwards, all outputs at reset values, next request proceeds normally.
